mdu_hazard_ctrl: RTL

MDU_HAZARD_CTRL -- requirements
Module: mdu_hazard_ctrl

---
 rtl/mdu_hazard_ctrl_if.sv | 26 ++
 rtl/mdu_hazard_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/mdu_hazard_ctrl_if.sv
// Handshake bundle between the pipeline hazard logic and the MDU hazard
// controller: D/E opcodes, E liveness, MDU busy feedback, and the controller's
// stall/issue/status outputs.
interface mdu_hazard_ctrl_if;
  logic [3:0]  d_md_op;
  logic [3:0]  e_md_op;
  logic        e_valid;
  logic        flush;
  logic        busy_in;
  logic        stall_d;
  logic        issue;
  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        err;
  logic [15:0] stall_cnt;

  modport master (
    output d_md_op, e_md_op, e_valid, flush, busy_in,
    input  stall_d, issue, state, cnt, err, stall_cnt
  );

  modport slave (
    input  d_md_op, e_md_op, e_valid, flush, busy_in,
    output stall_d, issue, state, cnt, err, stall_cnt
  );
endinterface

// File: rtl/mdu_hazard_ctrl.sv
// MDU hazard controller: predicts multiply/divide unit occupancy with a
// down-counter, hands start opcodes to the MDU, stalls MDU-class instructions
// in D while the unit is (or is about to become) busy, flags any disagreement
// between the predicted and reported busy state, and counts stall cycles.
module mdu_hazard_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic              clk,
  input  logic              reset,
  mdu_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);
  localparam logic [3:0] DIV_LAT_C = 4'(DIV_LAT);

  // Stall counter saturates instead of wrapping so long stalls stay visible.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_err, w_err_nxt;
  logic [15:0] r_stall_cnt, w_stall_cnt_nxt;

  logic w_e_live;
  logic w_e_start;
  logic w_e_is_mul;
  logic w_d_mdu;
  logic w_busy_pred;
  logic w_issue;
  logic w_stall_d;
  logic w_illegal;

  // Codes 9-15 fall outside both ranges and therefore behave as "none".
  assign w_e_live    = bus.e_valid & ~bus.flush;
  assign w_e_start   = (bus.e_md_op >= OP_MULT) && (bus.e_md_op <= OP_DIVU);
  assign w_e_is_mul  = (bus.e_md_op == OP_MULT) || (bus.e_md_op == OP_MULTU);
  assign w_d_mdu     = (bus.d_md_op >= OP_MULT) && (bus.d_md_op <= OP_MTLO);
  assign w_busy_pred = (r_cnt != 4'd0);

  // A live start can only be handed over when the unit is predicted idle;
  // a live start arriving while busy is a pipeline bug, flagged not issued.
  assign w_issue   = w_e_live & w_e_start & ~w_busy_pred;
  assign w_illegal = w_e_live & w_e_start &  w_busy_pred;
  assign w_stall_d = w_d_mdu & (w_busy_pred | (w_e_live & w_e_start));

  assign bus.issue     = w_issue;
  assign bus.stall_d   = w_stall_d;
  assign bus.state     = r_state;
  assign bus.cnt       = r_cnt;
  assign bus.err       = r_err;
  assign bus.stall_cnt = r_stall_cnt;

  // Next-state: load latency on issue, otherwise count down to idle.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_err_nxt       = r_err | (bus.busy_in != w_busy_pred) | w_illegal;
    w_stall_cnt_nxt = w_stall_d ? sat_inc16(r_stall_cnt) : r_stall_cnt;
    if (w_issue) begin
      w_cnt_nxt   = w_e_is_mul ? MUL_LAT_C : DIV_LAT_C;
      w_state_nxt = w_e_is_mul ? ST_MUL : ST_DIV;
    end else if (w_busy_pred) begin
      w_cnt_nxt = r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  // State registers; reset wins over issue and masks busy_in for err.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_err       <= 1'b0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_err       <= w_err_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

endmodule
